// File: rtl/pf_refill_pkg.sv
// Shared types and line geometry for the prefetch refill controller.
package pf_refill_pkg;

    localparam int LINE_OFFSET_W = 4;
    localparam int LINE_BYTES    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } pf_refill_state_e;

endpackage

// File: rtl/pf_addr_ring.sv
// Circular line-address buffer with write/issue/retire pointers.
// With PF_REFILL_DEDUP_EN defined it also reports which live entries match a probe address.
module pf_addr_ring #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              issue,
    input  logic              retire,
    input  logic              drop_pending,
    output logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [PTR_W-1:0]  n_tot,
    output logic [PTR_W-1:0]  n_fly,
    output logic              pending
`ifdef PF_REFILL_DEDUP_EN
    ,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic [DEPTH-1:0]  match_vec
`endif
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  iss_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // One extra pointer bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            iss_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            if (drop_pending) begin
                wr_ptr <= iss_ptr;
            end else if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                iss_ptr <= iss_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_addr;
        end
    end

    assign iss_addr = mem[iss_ptr[IDX_W-1:0]];
    assign rd_addr  = mem[rd_ptr[IDX_W-1:0]];
    assign n_tot    = wr_ptr - rd_ptr;
    assign n_fly    = iss_ptr - rd_ptr;
    assign pending  = (iss_ptr != wr_ptr);

`ifdef PF_REFILL_DEDUP_EN
    logic [IDX_W-1:0] rd_idx;
    assign rd_idx = rd_ptr[IDX_W-1:0];

    // An entry is live when its distance from rd_ptr is below the occupancy.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, IDX_W'(i) - rd_idx} < n_tot) && (mem[i] == cmp_addr)) begin
                match_vec[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/pf_refill_ctrl.sv
// Prefetch line request responder: buffers line requests, issues L2 refills, writes returned lines.
// Optional duplicate-request suppression is built when PF_REFILL_DEDUP_EN is defined.
//
//   state  | meaning
//   IDLE   | buffer empty, nothing outstanding
//   ACTIVE | accepting requests, issuing refills, retiring responses
//   FLUSH  | unissued entries dropped; waiting for in-flight refills to return
module pf_refill_ctrl
    import pf_refill_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pf_req_i,
    input  logic [ADDR_W-1:0] pf_addr_i,
    output logic              pf_gnt_o,
    output logic              pf_rvalid_o,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              refill_req_o,
    output logic [ADDR_W-1:0] refill_addr_o,
    input  logic              refill_gnt_i,
    input  logic              refill_rvalid_i,
    input  logic [LINE_W-1:0] refill_rdata_i,
    output logic              line_we_o,
    output logic [ADDR_W-1:0] line_addr_o,
    output logic [LINE_W-1:0] line_data_o,
    output logic              err_o
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0]  DEPTH_P  = PTR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

    if (((1 << LINE_OFFSET_W) != LINE_BYTES) || (LINE_W != 8 * LINE_BYTES)) begin : g_bad_cfg
        $error("pf_refill_ctrl: LINE_W must equal 8*LINE_BYTES");
    end

    pf_refill_state_e  state;
    logic [ADDR_W-1:0] req_line;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [PTR_W-1:0]  n_tot;
    logic [PTR_W-1:0]  n_fly;
    logic              pending;
    logic              push;
    logic              issue;
    logic              retire;

    assign req_line      = pf_addr_i & ~OFF_MASK;
    assign pf_gnt_o      = pf_req_i && (n_tot < DEPTH_P) && (state != FLUSH);
    assign refill_req_o  = pending && (state == ACTIVE);
    assign refill_addr_o = refill_req_o ? iss_addr : '0;
    assign issue         = refill_req_o && refill_gnt_i;
    assign retire        = refill_rvalid_i && (n_fly != '0);
    assign busy_o        = (state != IDLE);

`ifdef PF_REFILL_DEDUP_EN
    localparam int OWE_W = PTR_W + 4;

    logic [DEPTH-1:0] match_vec;
    logic             last_vld;
    logic             dup;
    logic [OWE_W-1:0] owed;
    logic [OWE_W-1:0] demand;

    // A duplicate is granted without a refill; its completion pulse may queue behind line writes.
    assign dup    = (|match_vec) || (last_vld && (line_addr_o == req_line));
    assign push   = pf_gnt_o && !dup;
    assign demand = owed + OWE_W'(retire) + OWE_W'(pf_gnt_o && dup);
`else
    assign push = pf_gnt_o;
`endif

    pf_addr_ring #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ring (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_addr    (req_line),
        .issue        (issue),
        .retire       (retire),
        .drop_pending (state == FLUSH),
        .iss_addr     (iss_addr),
        .rd_addr      (rd_addr),
        .n_tot        (n_tot),
        .n_fly        (n_fly),
        .pending      (pending)
`ifdef PF_REFILL_DEDUP_EN
        ,
        .cmp_addr     (req_line),
        .match_vec    (match_vec)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            line_we_o   <= 1'b0;
            pf_rvalid_o <= 1'b0;
            line_addr_o <= '0;
            line_data_o <= '0;
            err_o       <= 1'b0;
`ifdef PF_REFILL_DEDUP_EN
            owed        <= '0;
            last_vld    <= 1'b0;
`endif
        end else begin
            line_we_o <= retire;
            if (retire) begin
                line_addr_o <= rd_addr;
                line_data_o <= refill_rdata_i;
            end
            if (refill_rvalid_i && (n_fly == '0)) begin
                err_o <= 1'b1;
            end
`ifdef PF_REFILL_DEDUP_EN
            pf_rvalid_o <= (demand != '0);
            owed        <= demand - OWE_W'(demand != '0);
            if (retire) begin
                last_vld <= 1'b1;
            end
`else
            pf_rvalid_o <= retire;
`endif
            // Exit checks use the occupancy as it will be after this edge.
            case (state)
                IDLE: begin
                    if (push) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (flush_i) begin
                        state <= FLUSH;
                    end else if (!push && (n_tot == PTR_W'(retire))) begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (n_fly == PTR_W'(retire)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pf_refill_ctrl.sv
// Scoreboard bench for pf_refill_ctrl (default build, duplicate suppression disabled).
module tb_pf_refill_ctrl;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pf_req_i = 1'b0;
    logic [ADDR_W-1:0] pf_addr_i = '0;
    logic              pf_gnt_o;
    logic              pf_rvalid_o;
    logic              flush_i = 1'b0;
    logic              busy_o;
    logic              refill_req_o;
    logic [ADDR_W-1:0] refill_addr_o;
    logic              refill_gnt_i = 1'b0;
    logic              refill_rvalid_i = 1'b0;
    logic [LINE_W-1:0] refill_rdata_i = '0;
    logic              line_we_o;
    logic [ADDR_W-1:0] line_addr_o;
    logic [LINE_W-1:0] line_data_o;
    logic              err_o;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int p0;

    logic [ADDR_W-1:0] iss_q[$];
    logic [ADDR_W-1:0] fly_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [LINE_W-1:0] wd_q[$];
    logic              exp_we = 1'b0;
    logic              exp_err = 1'b0;

    always #5 clk = ~clk;

    pf_refill_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pf_req_i        (pf_req_i),
        .pf_addr_i       (pf_addr_i),
        .pf_gnt_o        (pf_gnt_o),
        .pf_rvalid_o     (pf_rvalid_o),
        .flush_i         (flush_i),
        .busy_o          (busy_o),
        .refill_req_o    (refill_req_o),
        .refill_addr_o   (refill_addr_o),
        .refill_gnt_i    (refill_gnt_i),
        .refill_rvalid_i (refill_rvalid_i),
        .refill_rdata_i  (refill_rdata_i),
        .line_we_o       (line_we_o),
        .line_addr_o     (line_addr_o),
        .line_data_o     (line_data_o),
        .err_o           (err_o)
    );

    task automatic chk(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock of stimulus; an expected grant queues the aligned line for issue.
    task automatic cyc(input logic req, input logic [ADDR_W-1:0] addr, input logic exp_gnt,
                       input logic l2g, input logic rv, input logic [LINE_W-1:0] rd, input logic fl);
        pf_req_i        = req;
        pf_addr_i       = addr;
        refill_gnt_i    = l2g;
        refill_rvalid_i = rv;
        refill_rdata_i  = rd;
        flush_i         = fl;
        #1;
        if (req) begin
            chk("pf_gnt", pf_gnt_o, exp_gnt);
            if (exp_gnt) iss_q.push_back({addr[ADDR_W-1:4], 4'h0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("iss_q_left", iss_q.size(), 0);
        chk("fly_q_left", fly_q.size(), 0);
        chk("wr_q_left", wa_q.size(), 0);
        chk("busy_idle", busy_o, 1'b0);
    endtask

    // Scoreboard: refill issues and responses feed expected line writes, checked one cycle later.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] a;
        if (!rst_n) begin
            iss_q.delete();
            fly_q.delete();
            wa_q.delete();
            wd_q.delete();
            exp_we  = 1'b0;
            exp_err = 1'b0;
        end else begin
            chk("line_we", line_we_o, exp_we);
            chk("pf_rvalid", pf_rvalid_o, exp_we);
            chk("err", err_o, exp_err);
            if (exp_we && wa_q.size() > 0) begin
                chk("line_addr", line_addr_o, wa_q.pop_front());
                chk("line_data", line_data_o, wd_q.pop_front());
            end
            if (pf_rvalid_o) pulses++;
            exp_we = 1'b0;
            if (refill_rvalid_i) begin
                if (fly_q.size() == 0) begin
                    exp_err = 1'b1;
                end else begin
                    a = fly_q.pop_front();
                    wa_q.push_back(a);
                    wd_q.push_back(refill_rdata_i);
                    exp_we = 1'b1;
                end
            end
            if (refill_req_o && refill_gnt_i) begin
                if (iss_q.size() == 0) begin
                    chk("spurious_issue", refill_req_o && refill_gnt_i, 1'b0);
                end else begin
                    a = iss_q.pop_front();
                    chk("refill_addr", refill_addr_o, a);
                    fly_q.push_back(a);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", pf_gnt_o, 1'b0);
        chk("rst_rvalid", pf_rvalid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_req", refill_req_o, 1'b0);
        chk("rst_raddr", refill_addr_o, '0);
        chk("rst_we", line_we_o, 1'b0);
        chk("rst_laddr", line_addr_o, '0);
        chk("rst_ldata", line_data_o, '0);
        chk("rst_err", err_o, 1'b0);
        rst_n = 1'b1;

        // single line, response three cycles after issue
        p0 = pulses;
        cyc(1'b1, 32'h1C00_0034, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        chk("single_busy", busy_o, 1'b1);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, {16{8'hA5}}, 1'b0);
        chk("single_idle", busy_o, 1'b0);
        drain(3);
        chk("single_pulses", pulses - p0, 1);

        // fill to DEPTH with L2 stalled; fifth request waits for a retire
        p0 = pulses;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(16 * i), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 32'h140, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 32'h140, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 32'h140, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 32'h140, 1'b0, 1'b1, 1'b1, {4{32'hF000_0000}}, 1'b0);
        cyc(1'b1, 32'h140, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 1; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, {4{32'hF000_0000 + 32'(i)}}, 1'b0);
        drain(3);
        chk("full_pulses", pulses - p0, 5);

        // streaming: one accept, one issue, one write per cycle
        p0 = pulses;
        for (int j = 0; j < 10; j++) begin
            cyc(j < 8, 32'h200 + 32'(16 * j), 1'b1, 1'b1, j >= 2, {4{32'hD000_0000 + 32'(j)}}, 1'b0);
        end
        drain(3);
        chk("stream_pulses", pulses - p0, 8);

        // flush with two lines in flight and two pending
        p0 = pulses;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h400 + 32'(16 * i), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        iss_q.delete();
        chk("flush_busy", busy_o, 1'b1);
        chk("flush_no_req", refill_req_o, 1'b0);
        cyc(1'b1, 32'h600, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, {4{32'hCAFE_0000}}, 1'b0);
        chk("flush_busy2", busy_o, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, {4{32'hCAFE_0001}}, 1'b0);
        chk("flush_done", busy_o, 1'b0);
        drain(3);
        chk("flush_pulses", pulses - p0, 2);

        // stray response sets the sticky error
        p0 = pulses;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, {4{32'hDEAD_BEEF}}, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("err_sticky", err_o, 1'b1);
        chk("err_pulses", pulses - p0, 0);

        // reset with three lines in flight
        cyc(1'b1, 32'h500, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 32'h510, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 32'h520, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("mid_fly", fly_q.size(), 3);
        p0 = pulses;
        rst_n = 1'b0;
        refill_gnt_i = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_gnt", pf_gnt_o, 1'b0);
        chk("mrst_rvalid", pf_rvalid_o, 1'b0);
        chk("mrst_busy", busy_o, 1'b0);
        chk("mrst_req", refill_req_o, 1'b0);
        chk("mrst_raddr", refill_addr_o, '0);
        chk("mrst_we", line_we_o, 1'b0);
        chk("mrst_laddr", line_addr_o, '0);
        chk("mrst_ldata", line_data_o, '0);
        chk("mrst_err", err_o, 1'b0);
        rst_n = 1'b1;
        drain(4);
        chk("mrst_pulses", pulses - p0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
